// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 keypad scanner: key code constants,
// scan-result and FSM state enums, and the row/column to code translation.
package keypad_pkg;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } scan_res_e;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } kp_state_e;

  // Digits occupy a 3x3 block (1..9) plus 0 under the centre of row 3.
  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    if (c == 2'd3) begin
      code = KEY_A + {2'b00, r};
    end else if (r == 2'd3) begin
      case (c)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for the asynchronous, active-low keypad row inputs.
// Resets to all-ones so an idle (pulled-up) keypad is seen immediately.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, per-scan reduction, debounce FSM and a
// valid/ready key output. Define AUTO_REPEAT_EN to re-emit held keys.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int DW_W  = $clog2(SCAN_DIV);
  localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;

  logic [3:0] row_s;

  sync_2ff #(.W(4)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (row),
    .q_o   (row_s)
  );

  logic [DW_W-1:0] dwell_q;
  logic [1:0]      col_idx_q;
  logic [3:0]      col_q;
  logic [15:0]     press_q;
  logic            scan_done_q;
  logic            last_dwell;

  assign last_dwell = (dwell_q == DW_W'(SCAN_DIV - 1));

  // press_q bit {r,c} holds "key down" from the most recent capture of column c
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell_q     <= '0;
      col_idx_q   <= '0;
      col_q       <= 4'b1110;
      press_q     <= '0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= last_dwell && (col_idx_q == 2'd3);
      if (last_dwell) begin
        dwell_q   <= '0;
        col_idx_q <= col_idx_q + 2'd1;
        col_q     <= {col_q[2:0], col_q[3]};
        for (int r = 0; r < 4; r++) begin
          press_q[{2'(r), col_idx_q}] <= ~row_s[r];
        end
      end else begin
        dwell_q <= dwell_q + 1'b1;
      end
    end
  end

  scan_res_e  res;
  logic [3:0] res_code;
  logic [4:0] n_down;

  always_comb begin
    n_down   = '0;
    res_code = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (press_q[{2'(r), 2'(c)}]) begin
          n_down   = n_down + 5'd1;
          res_code = keymap(2'(r), 2'(c));
        end
      end
    end
    if (n_down == 5'd0)      res = NONE;
    else if (n_down == 5'd1) res = SINGLE;
    else                     res = MULTI;
  end

  kp_state_e        state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             overrun_q;
  logic             cnt_last;
  logic             rep_emit;
  logic             emit_d;
  logic [3:0]       emit_code_d;

  assign cnt_last = (cnt_q == CNT_W'(DEBOUNCE_CNT - 1));

`ifdef AUTO_REPEAT_EN
  logic [15:0] rep_cnt_q;
  logic        rep_first_q;
  logic        rep_hit;

  assign rep_hit  = rep_first_q ? (rep_cnt_q == 16'(REPEAT_DELAY - 1))
                                : (rep_cnt_q == 16'(REPEAT_RATE - 1));
  assign rep_emit = (state_q == PRESSED) && (res != NONE) && rep_hit;

  // Counts held scans while PRESSED; the first period is the longer delay
  always_ff @(posedge clk) begin
    if (!rst_n || (state_q != PRESSED)) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (scan_done_q && (res != NONE)) begin
      if (rep_hit) begin
        rep_cnt_q   <= '0;
        rep_first_q <= 1'b0;
      end else begin
        rep_cnt_q <= rep_cnt_q + 16'd1;
      end
    end
  end
`else
  logic unused_rep;
  assign rep_emit   = 1'b0;
  assign unused_rep = (REPEAT_DELAY == REPEAT_RATE);
`endif

  always_comb begin
    emit_d      = 1'b0;
    emit_code_d = res_code;
    if (scan_done_q) begin
      case (state_q)
        IDLE:     emit_d = (res == SINGLE) && (DEBOUNCE_CNT == 1);
        DEBOUNCE: emit_d = (res == SINGLE) && (res_code == cand_q) && cnt_last;
        PRESSED: begin
          emit_d      = rep_emit;
          emit_code_d = cand_q;
        end
        default:  emit_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      // A pending key that is not being taken this cycle blocks the new one
      if (emit_d) begin
        if (!key_valid_q || key_ready) begin
          key_code_q  <= emit_code_d;
          key_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (key_valid_q && key_ready) begin
        key_valid_q <= 1'b0;
      end

      if (scan_done_q) begin
        case (state_q)
          IDLE: begin
            if (res == SINGLE) begin
              cand_q  <= res_code;
              cnt_q   <= CNT_W'(1);
              state_q <= (DEBOUNCE_CNT == 1) ? PRESSED : DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (res != SINGLE) begin
              state_q <= IDLE;
            end else if (res_code != cand_q) begin
              cand_q <= res_code;
              cnt_q  <= CNT_W'(1);
            end else if (cnt_last) begin
              state_q <= PRESSED;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PRESSED: begin
            if (res == NONE) begin
              cnt_q   <= CNT_W'(1);
              state_q <= (DEBOUNCE_CNT == 1) ? IDLE : RELEASE;
            end
          end
          RELEASE: begin
            if (res != NONE) begin
              state_q <= PRESSED;
            end else if (cnt_last) begin
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;
  assign key_held  = (state_q == PRESSED) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a combinational keypad matrix driven by a key mask,
// with expected keys derived from a sliding window of whole-scan results.
module tb_keypad_scanner;

  localparam int DC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_held;
  logic        overrun;
  logic [15:0] mask;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rows_of(input logic [15:0] m, input logic [3:0] cl);
    logic [3:0] rw;
    rw = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m[r*4+c] && !cl[c]) rw[r] = 1'b0;
    return rw;
  endfunction

  assign row = rows_of(mask, col);

  // Layout index r*4+c: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  int keytab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  int n_cmp = 0;
  int n_fail = 0;
  int ovr_cnt = 0;
  int rx_q[$];
  int exp_q[$];
  int hist[$];
  bit m_held;
  bit cmp_emit;
  int n_rx;
  int last_code;
  logic [15:0] prev_mask;

  task automatic chk(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) rx_q.push_back(int'(key_code));
    if (overrun) ovr_cnt++;
  end

  // A key is accepted once when the last DC scans were all the same single key,
  // and released when the last DC scans were all empty.
  task automatic model_step(input logic [15:0] m);
    int n, k, res;
    bit same;
    n = 0;
    k = 0;
    for (int i = 0; i < 16; i++) if (m[i]) begin n++; k = keytab[i]; end
    res = (n == 0) ? -1 : ((n == 1) ? k : -2);
    hist.push_back(res);
    if (hist.size() > DC) void'(hist.pop_front());
    if (hist.size() == DC) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != res) same = 1'b0;
      if (!m_held && same && res >= 0) begin
        m_held = 1'b1;
        exp_q.push_back(res);
      end else if (m_held && same && res == -1) begin
        m_held = 1'b0;
      end
    end
  endtask

  // Entered just after a scan boundary; the previous scan is judged at the end.
  task automatic do_scan(input logic [15:0] m);
    mask = m;
    repeat (16) @(posedge clk);
    #1;
    model_step(prev_mask);
    prev_mask = m;
    chk("held", int'(key_held), int'(m_held));
    if (cmp_emit) begin
      chk("n_emit", rx_q.size(), exp_q.size());
      n_rx += rx_q.size();
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
        last_code = rx_q.pop_front();
        chk("code", last_code, exp_q.pop_front());
      end
      rx_q.delete();
    end
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, want $finish");
    $fatal(1);
  end

  initial begin
    int n0, o0;
    logic [3:0] col_seq [4];
    col_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst_n = 1'b0;
    key_ready = 1'b1;
    mask = '0;
    prev_mask = '0;
    m_held = 1'b0;
    cmp_emit = 1'b1;
    n_rx = 0;
    last_code = -1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", int'(col), 4'b1110);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_held", int'(key_held), 0);
    chk("rst_code", int'(key_code), 0);
    chk("rst_ovr", int'(overrun), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(posedge clk);
      #1;
      chk("col_rot", int'(col), int'(col_seq[i]));
    end

    // Hold '6' (row1/col2) for 10 scans, then release
    n0 = n_rx;
    last_code = -1;
    repeat (10) do_scan(16'h0040);
    repeat (3) do_scan(16'h0000);
    chk("hold6_n", n_rx - n0, 1);
    chk("hold6_code", last_code, 6);

    // Bounce on '2' (row0/col1)
    n0 = n_rx;
    repeat (4) begin
      do_scan(16'h0002);
      do_scan(16'h0000);
    end
    do_scan(16'h0000);
    chk("bounce_n", n_rx - n0, 0);

    // Ghost: '1' and '2' together
    n0 = n_rx;
    repeat (5) do_scan(16'h0003);
    do_scan(16'h0000);
    chk("ghost_n", n_rx - n0, 0);

    // Random key activity
    o0 = ovr_cnt;
    for (int s = 0; s < 30; s++) begin
      logic [15:0] m;
      int sel, a, b, len;
      sel = $urandom_range(0, 9);
      a = $urandom_range(0, 15);
      b = (a + 1 + $urandom_range(0, 14)) % 16;
      if (sel < 3)      m = '0;
      else if (sel < 8) m = 16'(1) << a;
      else              m = (16'(1) << a) | (16'(1) << b);
      len = $urandom_range(1, 4);
      repeat (len) do_scan(m);
    end
    repeat (3) do_scan(16'h0000);
    chk("rand_ovr", ovr_cnt - o0, 0);

    // Overrun: '5' left pending while '#' is pressed
    cmp_emit = 1'b0;
    key_ready = 1'b0;
    o0 = ovr_cnt;
    repeat (3) do_scan(16'h0020);
    repeat (3) do_scan(16'h0000);
    repeat (3) do_scan(16'h4000);
    repeat (2) do_scan(16'h0000);
    chk("ovr_valid", int'(key_valid), 1);
    chk("ovr_code", int'(key_code), 5);
    chk("ovr_pulses", ovr_cnt - o0, 1);
    chk("ovr_no_xfer", rx_q.size(), 0);
    key_ready = 1'b1;
    @(posedge clk);
    #1;
    key_ready = 1'b0;
    chk("ovr_kv_clr", int'(key_valid), 0);
    chk("ovr_xfer_n", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("ovr_xfer_code", rx_q[0], 5);
    repeat (15) @(posedge clk);
    #1;
    model_step(prev_mask);
    prev_mask = mask;
    rx_q.delete();
    exp_q.delete();
    key_ready = 1'b1;
    cmp_emit = 1'b1;
    do_scan(16'h0000);
    do_scan(16'h0000);

    // Reset one scan into debouncing '0' (row3/col1)
    mask = 16'h2000;
    repeat (18) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_valid", int'(key_valid), 0);
    chk("mid_rst_held", int'(key_held), 0);
    chk("mid_rst_col", int'(col), 4'b1110);
    chk("mid_rst_rx", rx_q.size(), 0);
    rst_n = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    hist.delete();
    exp_q.delete();
    m_held = 1'b0;
    prev_mask = 16'h2000;
    n0 = n_rx;
    last_code = -1;
    repeat (2) do_scan(16'h2000);
    repeat (3) do_scan(16'h0000);
    chk("rst_reemit_n", n_rx - n0, 1);
    chk("rst_reemit_code", last_code, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
